// File: rtl/reg_file_pkg.sv
// Shared widths, index types and decode helpers
// for the 32 x 32 register file.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam int UP_W  = 2;
  localparam int LO_W  = 3;
  localparam int GRPS  = 2 ** UP_W;
  localparam int GRP_N = 2 ** LO_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] idx_t;
  typedef logic [UP_W-1:0]   up_sel_t;
  typedef logic [LO_W-1:0]   lo_sel_t;

  function automatic logic [GRPS-1:0] dec2to4(
    input logic    en,
    input up_sel_t sel
  );
    logic [GRPS-1:0] oh;
    oh = '0;
    if (en) oh[sel] = 1'b1;
    return oh;
  endfunction

  function automatic logic hit3(
    input logic    en,
    input lo_sel_t sel,
    input lo_sel_t k
  );
    return en && (sel == k);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Read/write port bundle of the register file.
// master drives indices and write data.
interface reg_file_if;
  import reg_file_pkg::*;

  idx_t  reg1n;
  idx_t  reg2n;
  idx_t  wregn;
  word_t wdata;
  logic  wen;
  word_t reg1o;
  word_t reg2o;

  modport master (
    output reg1n,
    output reg2n,
    output wregn,
    output wdata,
    output wen,
    input  reg1o,
    input  reg2o
  );

  modport slave (
    input  reg1n,
    input  reg2n,
    input  wregn,
    input  wdata,
    input  wen,
    output reg1o,
    output reg2o
  );

endinterface

// File: rtl/reg_file_reg32.sv
// One 32-bit storage register with synchronous
// clear and load enable.
module reg32
  import reg_file_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  word_t d,
  output word_t q
);

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file: two combinational read
// ports, one synchronous write port, r0 tied to 0.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic  clk,
  input logic  reset,
  reg_file_if.slave bus
);
  import reg_file_pkg::*;

  localparam int NREG = 2 ** ADDR_W;

  logic [GRPS-1:0]             upper;
  logic [NREG-1:1]             wsel;
  logic [NREG-1:0][DATA_W-1:0] regs;

  // Upper decode stage, gated by the write enable.
  always_comb begin
    upper = dec2to4(bus.wen, bus.wregn[4:3]);
  end

  assign regs[0] = '0;

  for (genvar g = 0; g < GRPS; g++) begin : g_grp
    for (genvar k = 0; k < GRP_N; k++) begin : g_reg
      localparam int IDX = g * GRP_N + k;
      if (IDX != 0) begin : g_store
        assign wsel[IDX] = hit3(
          upper[g],
          bus.wregn[2:0],
          lo_sel_t'(k)
        );
        reg32 u_reg (
          .clk   (clk),
          .reset (reset),
          .en    (wsel[IDX]),
          .d     (bus.wdata),
          .q     (regs[IDX])
        );
      end
    end
  end

  // Read port 1: plain 32:1 mux, no bypass.
  always_comb begin
    bus.reg1o = regs[bus.reg1n];
  end

  // Read port 2: independent 32:1 mux.
  always_comb begin
    bus.reg2o = regs[bus.reg2n];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an
// array model of the register contents.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] model [32];
  int checks   = 0;
  int failures = 0;

  task automatic tick();
    logic        r;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    r = reset;
    w = bus.wen;
    a = bus.wregn;
    d = bus.wdata;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (w === 1'b1 && a != 0) begin
      model[a] = d;
    end
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.wen   = 1'b1;
    bus.wregn = 5'd9;
    bus.wdata = $urandom();
    tick();
    reset   = 1'b0;
    bus.wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.reg1n = 5'(i);
      bus.reg2n = 5'(31 - i);
      #1;
      checks++;
      if (bus.reg1o !== 32'h0 || bus.reg2o !== 32'h0) begin
        failures++;
        $display("FAIL reset idx=%0d p1=%h p2=%h want 0",
                 i, bus.reg1o, bus.reg2o);
      end
    end
  endtask

  task automatic test_basic_write();
    bus.wen   = 1'b1;
    bus.wregn = 5'd2;
    bus.wdata = 32'hABCD1234;
    tick();
    bus.wen   = 1'b0;
    bus.reg1n = 5'd2;
    bus.reg2n = 5'd2;
    #1;
    checks++;
    if (bus.reg1o !== 32'hABCD1234 ||
        bus.reg2o !== 32'hABCD1234) begin
      failures++;
      $display("FAIL write_r2 p1=%h p2=%h want abcd1234",
               bus.reg1o, bus.reg2o);
    end
    bus.wen   = 1'b1;
    bus.wregn = 5'd31;
    bus.wdata = 32'hDEADBEEF;
    tick();
    bus.wen   = 1'b0;
    bus.reg1n = 5'd31;
    bus.reg2n = 5'd31;
    #1;
    checks++;
    if (bus.reg1o !== 32'hDEADBEEF ||
        bus.reg2o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_r31 p1=%h p2=%h want deadbeef",
               bus.reg1o, bus.reg2o);
    end
    bus.reg1n = 5'd2;
    #1;
    checks++;
    if (bus.reg1o !== 32'hABCD1234) begin
      failures++;
      $display("FAIL keep_r2 got=%h want abcd1234",
               bus.reg1o);
    end
  endtask

  task automatic test_wen_low();
    bus.wen   = 1'b0;
    bus.wregn = 5'd5;
    bus.wdata = 32'hFFFFFFFF;
    tick();
    bus.reg1n = 5'd5;
    bus.reg2n = 5'd5;
    #1;
    checks++;
    if (bus.reg1o === 32'hFFFFFFFF ||
        bus.reg1o !== model[5] ||
        bus.reg2o !== model[5]) begin
      failures++;
      $display("FAIL wen_low p1=%h p2=%h want %h",
               bus.reg1o, bus.reg2o, model[5]);
    end
  endtask

  task automatic test_mid_reset();
    reset   = 1'b1;
    bus.wen = 1'b0;
    tick();
    reset     = 1'b0;
    bus.reg1n = 5'd2;
    bus.reg2n = 5'd31;
    #1;
    checks++;
    if (bus.reg1o !== 32'h0 || bus.reg2o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset p1=%h p2=%h want 0",
               bus.reg1o, bus.reg2o);
    end
  endtask

  task automatic test_zero_write();
    bus.wen   = 1'b1;
    bus.wregn = 5'd0;
    bus.wdata = 32'hFFFFFFFF;
    tick();
    bus.wen   = 1'b0;
    bus.reg1n = 5'd0;
    bus.reg2n = 5'd0;
    #1;
    checks++;
    if (bus.reg1o !== 32'h0 || bus.reg2o !== 32'h0) begin
      failures++;
      $display("FAIL zero_write p1=%h p2=%h want 0",
               bus.reg1o, bus.reg2o);
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom() | 32'h1;
    b = ~a;
    bus.wen   = 1'b1;
    bus.wregn = 5'd7;
    bus.wdata = a;
    tick();
    bus.wdata = b;
    bus.reg1n = 5'd7;
    bus.reg2n = 5'd7;
    #1;
    checks++;
    if (bus.reg1o !== a || bus.reg2o !== a) begin
      failures++;
      $display("FAIL no_bypass p1=%h p2=%h want %h",
               bus.reg1o, bus.reg2o, a);
    end
    tick();
    checks++;
    if (bus.reg1o !== b || bus.reg2o !== b) begin
      failures++;
      $display("FAIL after_edge p1=%h p2=%h want %h",
               bus.reg1o, bus.reg2o, b);
    end
    reset     = 1'b1;
    bus.wdata = 32'h12345678;
    tick();
    reset   = 1'b0;
    bus.wen = 1'b0;
    #1;
    checks++;
    if (bus.reg1o !== 32'h0) begin
      failures++;
      $display("FAIL reset_prio got=%h want 0",
               bus.reg1o);
    end
  endtask

  task automatic test_x_data();
    for (int i = 1; i < 32; i++) begin
      bus.wen   = 1'b1;
      bus.wregn = 5'(i);
      bus.wdata = $urandom();
      tick();
    end
    bus.wen   = 1'b0;
    bus.wregn = 5'($urandom_range(31, 1));
    bus.wdata = 'x;
    tick();
    bus.wdata = '0;
    for (int i = 0; i < 32; i++) begin
      bus.reg1n = 5'(i);
      bus.reg2n = 5'(i);
      #1;
      checks++;
      if (bus.reg1o !== model[i] ||
          bus.reg2o !== model[i]) begin
        failures++;
        $display("FAIL x_data idx=%0d p1=%h p2=%h want %h",
                 i, bus.reg1o, bus.reg2o, model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bus.wen   = 1'b1;
      bus.wregn = (i < 4) ? 5'd13 : 5'(i + 14);
      bus.wdata = $urandom();
      bus.reg1n = bus.wregn;
      bus.reg2n = 5'd13;
      #1;
      checks++;
      if (bus.reg1o !== model[bus.reg1n] ||
          bus.reg2o !== model[13]) begin
        failures++;
        $display("FAIL b2b i=%0d p1=%h p2=%h want %h %h",
                 i, bus.reg1o, bus.reg2o,
                 model[bus.reg1n], model[13]);
      end
      tick();
    end
    bus.wen = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(39, 0) == 0);
      bus.wen   = $urandom_range(1, 0) == 1;
      bus.wregn = 5'($urandom_range(31, 0));
      bus.wdata = $urandom();
      bus.reg1n = 5'($urandom_range(31, 0));
      bus.reg2n = ($urandom_range(3, 0) == 0) ?
                  bus.wregn : 5'($urandom_range(31, 0));
      #1;
      checks++;
      if (bus.reg1o !== model[bus.reg1n] ||
          bus.reg2o !== model[bus.reg2n]) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random n=%0d i1=%0d p1=%h want %h i2=%0d p2=%h want %h",
                   n, bus.reg1n, bus.reg1o,
                   model[bus.reg1n], bus.reg2n,
                   bus.reg2o, model[bus.reg2n]);
      end
      tick();
    end
    reset   = 1'b0;
    bus.wen = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    bus.wen   = 1'b0;
    bus.wregn = '0;
    bus.wdata = '0;
    bus.reg1n = '0;
    bus.reg2n = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #2;
    test_reset();
    test_basic_write();
    test_wen_low();
    test_mid_reset();
    test_zero_write();
    test_reset_priority();
    test_x_data();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
